// File: rtl/multi_chan_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_chan_addr_gen_if
//  Brief    : Load/step/kill control and per-channel status bus for the
//             multi-channel address generator.
//  Revision : 1.0  initial release
// ============================================================================
interface multi_chan_addr_gen_if #(
    parameter int W   = 16,
    parameter int CH  = 4,
    parameter int CHW = 2
);
    logic            ld;
    logic [CHW-1:0]  ld_ch;
    logic [W-1:0]    ld_base;
    logic [W-1:0]    ld_stride;
    logic [W-1:0]    ld_len;
    logic            ld_wrap;
    logic            step;
    logic [CHW-1:0]  step_ch;
    logic            kill;
    logic [CH*W-1:0] base;
    logic [CH*W-1:0] addr;
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;

    // Controller side: issues loads/steps, observes channel status
    modport master (
        output ld, ld_ch, ld_base, ld_stride, ld_len, ld_wrap,
        output step, step_ch, kill,
        input  base, addr, cnt, busy, done
    );

    // Generator side
    modport slave (
        input  ld, ld_ch, ld_base, ld_stride, ld_len, ld_wrap,
        input  step, step_ch, kill,
        output base, addr, cnt, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/multi_chan_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_chan_addr_gen
//  Brief    : CH independent address channels. Each is loaded with base,
//             stride, length and wrap mode, then steps addr by stride on
//             request; one-shot or circular, with a 1-cycle done per pass.
//  Revision : 1.0  initial release
// ============================================================================
module multi_chan_addr_gen #(
    parameter int W   = 16,
    parameter int CH  = 4,
    parameter int CHW = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    multi_chan_addr_gen_if.slave  bus
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        // Out-of-range channel selects never match any index, so they are ignored
        localparam logic [CHW-1:0] c_IDX = CHW'(i);

        logic [1:0]   r_state, w_state_nx;
        logic [W-1:0] r_base,  w_base_nx;
        logic [W-1:0] r_addr,  w_addr_nx;
        logic [W-1:0] r_cnt,   w_cnt_nx;
        logic [W-1:0] r_stride, w_stride_nx;
        logic [W-1:0] r_len,   w_len_nx;
        logic         r_wrap,  w_wrap_nx;
        logic         r_done,  w_done_nx;
        logic         w_ld_hit;
        logic         w_step_hit;
        logic         w_last;

        assign w_ld_hit   = bus.ld && (bus.ld_ch == c_IDX);
        assign w_step_hit = bus.step && (bus.step_ch == c_IDX) && (r_state == c_S_RUN);
        // len is never zero while in RUN, so len-1 does not underflow here
        assign w_last     = (r_cnt == (r_len - W'(1)));

        // Next-state and next-register values; kill beats load beats step
        always_comb begin
            w_state_nx  = r_state;
            w_base_nx   = r_base;
            w_addr_nx   = r_addr;
            w_cnt_nx    = r_cnt;
            w_stride_nx = r_stride;
            w_len_nx    = r_len;
            w_wrap_nx   = r_wrap;
            w_done_nx   = 1'b0;
            if (bus.kill) begin
                w_state_nx = c_S_IDLE;
            end else if (w_ld_hit) begin
                w_base_nx   = bus.ld_base;
                w_addr_nx   = bus.ld_base;
                w_cnt_nx    = '0;
                w_stride_nx = bus.ld_stride;
                w_len_nx    = bus.ld_len;
                w_wrap_nx   = bus.ld_wrap;
                if (bus.ld_len != '0) begin
                    w_state_nx = c_S_RUN;
                end else begin
                    w_state_nx = c_S_DONE;
                    w_done_nx  = 1'b1;
                end
            end else if (w_step_hit) begin
                if (w_last) begin
                    w_done_nx = 1'b1;
                    if (r_wrap) begin
                        w_addr_nx = r_base;
                        w_cnt_nx  = '0;
                    end else begin
                        // addr has advanced by stride each step, so this equals base+len*stride
                        w_addr_nx  = r_addr + r_stride;
                        w_cnt_nx   = r_len;
                        w_state_nx = c_S_DONE;
                    end
                end else begin
                    w_addr_nx = r_addr + r_stride;
                    w_cnt_nx  = r_cnt + W'(1);
                end
            end
        end

        // Channel state register with asynchronous reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state  <= c_S_IDLE;
                r_base   <= '0;
                r_addr   <= '0;
                r_cnt    <= '0;
                r_stride <= '0;
                r_len    <= '0;
                r_wrap   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_state  <= w_state_nx;
                r_base   <= w_base_nx;
                r_addr   <= w_addr_nx;
                r_cnt    <= w_cnt_nx;
                r_stride <= w_stride_nx;
                r_len    <= w_len_nx;
                r_wrap   <= w_wrap_nx;
                r_done   <= w_done_nx;
            end
        end

        assign bus.base[i*W +: W] = r_base;
        assign bus.addr[i*W +: W] = r_addr;
        assign bus.cnt[i*W +: W]  = r_cnt;
        assign bus.busy[i]        = (r_state == c_S_RUN);
        assign bus.done[i]        = r_done;
    end

endmodule
`default_nettype wire
